ir_frame_buffer: RTL and testbench

Ping-pong frame store that sits directly downstream of the UART thermal-camera decoder. It captures one 32x24 frame of 8-bit normalised pixels per header sync into a write bank. When a frame is complete, it hands the bank to the NICE-side consumer, which reads it by address. Frames that arrive while the consumer still holds the read bank are dropped and counted, never torn.

---
 rtl/ir_fb_pkg.sv | 6 +
 rtl/ir_fb_ram.sv | 22 ++
 rtl/ir_frame_buffer.sv | 119 +++++++++++
 tb/tb_ir_frame_buffer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ir_fb_pkg.sv
// ir_fb_pkg: shared constants and write-FSM state type for the ping-pong IR frame store.
package ir_fb_pkg;
    localparam int          FRAME_PIX = 32 * 24;
    localparam logic [15:0] HDR_SYNC  = 16'h5A5A;
    typedef enum logic [1:0] {IDLE, FILL, DONE} wr_state_e;
endpackage

// File: rtl/ir_fb_ram.sv
// ir_fb_ram: simple dual-port RAM, one write port and one registered read port.
module ir_fb_ram
    import ir_fb_pkg::*;
#(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/ir_frame_buffer.sv
// ir_frame_buffer: ping-pong store for 32x24 thermal frames; the write bank fills
// while the consumer reads the other, and frames arriving while it is busy are dropped.
module ir_frame_buffer
    import ir_fb_pkg::*;
#(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 24,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_sync,
    input  logic              pix_stb,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              rd_release,
    output logic              frame_avail,
    output logic [7:0]        frame_id,
    output logic [7:0]        drop_cnt,
    output logic              err_short
);
    localparam int NPIX = IMG_W * IMG_H;

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wr_bank_q, wr_bank_d;
    logic              frame_avail_q, frame_avail_d;
    logic [7:0]        frame_id_q, frame_id_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              err_short_q, err_short_d;
    logic              rd_valid_q, rd_zero_q, rd_zero_d;
    logic              wr_en, commit;
    logic [PIX_W-1:0]  ram_q;

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        wr_bank_d   = wr_bank_q;
        frame_id_d  = frame_id_q;
        drop_cnt_d  = drop_cnt_q;
        err_short_d = 1'b0;
        wr_en       = 1'b0;
        commit      = (state_q == DONE) && (!frame_avail_q || rd_release);
        frame_avail_d = commit ? 1'b1 : (rd_release ? 1'b0 : frame_avail_q);
        case (state_q)
            IDLE: if (frame_sync) begin
                state_d   = FILL;
                wr_addr_d = '0;
            end
            FILL: if (frame_sync) begin
                err_short_d = 1'b1;
                wr_addr_d   = '0;
            end else if (pix_stb) begin
                wr_en     = 1'b1;
                wr_addr_d = wr_addr_q + 1'b1;
                if (wr_addr_q == ADDR_W'(NPIX - 1)) state_d = DONE;
            end
            DONE: begin
                if (commit) begin
                    wr_bank_d  = ~wr_bank_q;
                    frame_id_d = frame_id_q + 8'd1;
                end else if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
                // a sync landing on the commit cycle starts the next frame directly
                state_d   = frame_sync ? FILL : IDLE;
                wr_addr_d = '0;
            end
            default: state_d = IDLE;
        endcase
        rd_zero_d = rd_en ? (int'(rd_addr) >= NPIX) : rd_zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_addr_q     <= '0;
            wr_bank_q     <= 1'b0;
            frame_avail_q <= 1'b0;
            frame_id_q    <= '0;
            drop_cnt_q    <= '0;
            err_short_q   <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_zero_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            wr_bank_q     <= wr_bank_d;
            frame_avail_q <= frame_avail_d;
            frame_id_q    <= frame_id_d;
            drop_cnt_q    <= drop_cnt_d;
            err_short_q   <= err_short_d;
            rd_valid_q    <= rd_en;
            rd_zero_q     <= rd_zero_d;
        end
    end

    ir_fb_ram #(.AW(ADDR_W + 1), .DW(PIX_W)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wr_bank_q, wr_addr_q}),
        .wdata (pix_data),
        .re    (rd_en),
        .raddr ({~wr_bank_q, rd_addr}),
        .rdata (ram_q)
    );

    // the RAM itself is not reset, so out-of-range reads and reset force zero here
    assign rd_data     = rd_zero_q ? '0 : ram_q;
    assign rd_valid    = rd_valid_q;
    assign frame_avail = frame_avail_q;
    assign frame_id    = frame_id_q;
    assign drop_cnt    = drop_cnt_q;
    assign err_short   = err_short_q;
endmodule

// File: tb/tb_ir_frame_buffer.sv
// tb_ir_frame_buffer: directed and random checks of ir_frame_buffer against a
// frame-level reference model (pixel queue plus last committed frame image).
module tb_ir_frame_buffer;
    import ir_fb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_sync = 1'b0, pix_stb = 1'b0, rd_en = 1'b0, rd_release = 1'b0;
    logic [7:0] pix_data = '0;
    logic [9:0] rd_addr = '0;
    logic [7:0] rd_data, frame_id, drop_cnt;
    logic       rd_valid, frame_avail, err_short;

    int checks = 0, errors = 0, err_seen = 0;

    int         m_phase;
    logic [7:0] m_fill[$];
    logic [7:0] m_frame[FRAME_PIX];
    bit         m_has, m_avail, m_err, m_valid, m_known;
    logic [7:0] m_id, m_drop, m_data;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    ir_frame_buffer dut (
        .clk(clk), .rst_n(rst_n), .frame_sync(frame_sync), .pix_stb(pix_stb),
        .pix_data(pix_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_release(rd_release), .frame_avail(frame_avail),
        .frame_id(frame_id), .drop_cnt(drop_cnt), .err_short(err_short)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase = 0;
        m_fill.delete();
        m_has = 0; m_avail = 0; m_err = 0; m_valid = 0; m_known = 1;
        m_id = 0; m_drop = 0; m_data = 0;
    endfunction

    // one clock edge of frame-level behaviour: 0 idle, 1 filling, 2 frame complete
    function automatic void model_step();
        bit commit;
        if (rd_en) begin
            m_valid = 1;
            if (int'(rd_addr) >= FRAME_PIX) begin m_data = 0; m_known = 1; end
            else if (m_has) begin m_data = m_frame[rd_addr]; m_known = 1; end
            else m_known = 0;
        end else m_valid = 0;
        commit = (m_phase == 2) && (!m_avail || rd_release);
        m_err = 0;
        if (m_phase == 2) begin
            if (commit) begin
                foreach (m_frame[i]) m_frame[i] = m_fill[i];
                m_id = m_id + 8'd1;
                m_has = 1;
            end else if (m_drop < 8'd255) m_drop = m_drop + 8'd1;
            m_fill.delete();
            m_phase = frame_sync ? 1 : 0;
        end else if (m_phase == 1) begin
            if (frame_sync) begin m_err = 1; m_fill.delete(); end
            else if (pix_stb) begin
                m_fill.push_back(pix_data);
                if (m_fill.size() == FRAME_PIX) m_phase = 2;
            end
        end else if (frame_sync) begin
            m_phase = 1;
            m_fill.delete();
        end
        m_avail = commit ? 1'b1 : (rd_release ? 1'b0 : m_avail);
    endfunction

    task automatic tick(bit s, bit p, logic [7:0] d, bit re, logic [9:0] ra, bit rel);
        frame_sync = s; pix_stb = p; pix_data = d; rd_en = re; rd_addr = ra; rd_release = rel;
        @(posedge clk);
        model_step();
        #1;
        err_seen += int'(err_short);
        chk("frame_avail", 32'(frame_avail), 32'(m_avail));
        chk("frame_id", 32'(frame_id), 32'(m_id));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("err_short", 32'(err_short), 32'(m_err));
        chk("rd_valid", 32'(rd_valid), 32'(m_valid));
        if (m_known) chk("rd_data", 32'(rd_data), 32'(m_data));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick(0, 0, 8'h00, 0, 10'd0, 0);
    endtask

    task automatic send_frame(int n, int start);
        tick(1, 0, 8'h00, 0, 10'd0, 0);
        for (int i = 0; i < n; i++) tick(0, 1, 8'(start + i), 0, 10'd0, 0);
    endtask

    task automatic read_chk(string nm, logic [9:0] a, logic [7:0] exp);
        tick(0, 0, 8'h00, 1, a, 0);
        chk(nm, 32'(rd_data), 32'(exp));
        chk("rd_valid_hi", 32'(rd_valid), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 0; frame_sync = 0; pix_stb = 0; rd_en = 0; rd_release = 0;
        #2;
        model_reset();
        chk("rst_frame_avail", 32'(frame_avail), 32'd0);
        chk("rst_frame_id", 32'(frame_id), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_err_short", 32'(err_short), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        rd_vec_t tab[6];
        tab[0] = '{10'd0, 8'd0};   tab[1] = '{10'd255, 8'd255};
        tab[2] = '{10'd256, 8'd0}; tab[3] = '{10'd767, 8'd255};
        tab[4] = '{10'd800, 8'd0}; tab[5] = '{10'd1023, 8'd0};

        // first frame, pixel value = index
        do_reset();
        send_frame(FRAME_PIX, 0);
        chk("avail_before_commit", 32'(frame_avail), 32'd0);
        idle(1);
        chk("avail_after_commit", 32'(frame_avail), 32'd1);
        chk("id_first", 32'(frame_id), 32'd1);
        foreach (tab[i]) read_chk($sformatf("tab_rd_%0d", tab[i].addr), tab[i].addr, tab[i].exp);
        idle(1);
        chk("rd_valid_lo", 32'(rd_valid), 32'd0);

        // unreleased frame is dropped, released one commits
        do_reset();
        send_frame(FRAME_PIX, 0);
        idle(1);
        send_frame(FRAME_PIX, 100);
        idle(1);
        chk("drop_one", 32'(drop_cnt), 32'd1);
        chk("id_after_drop", 32'(frame_id), 32'd1);
        read_chk("rd_after_drop", 10'd0, 8'd0);
        tick(0, 0, 8'h00, 0, 10'd0, 1);
        chk("avail_released", 32'(frame_avail), 32'd0);
        send_frame(FRAME_PIX, 200);
        idle(1);
        chk("id_third", 32'(frame_id), 32'd2);
        read_chk("rd_third", 10'd0, 8'd200);

        // short frame
        do_reset();
        err_seen = 0;
        send_frame(100, 7);
        send_frame(FRAME_PIX, 3);
        idle(1);
        chk("err_once", 32'(err_seen), 32'd1);
        chk("id_short", 32'(frame_id), 32'd1);
        read_chk("rd_short", 10'd10, 8'd13);

        // release on the commit cycle
        do_reset();
        send_frame(FRAME_PIX, 0);
        idle(1);
        send_frame(FRAME_PIX, 50);
        tick(0, 0, 8'h00, 0, 10'd0, 1);
        chk("avail_rel_commit", 32'(frame_avail), 32'd1);
        chk("id_rel_commit", 32'(frame_id), 32'd2);
        chk("drop_rel_commit", 32'(drop_cnt), 32'd0);
        read_chk("rd_rel_commit", 10'd0, 8'd50);

        // sync coincident with a strobe
        do_reset();
        tick(1, 1, 8'hEE, 0, 10'd0, 0);
        for (int i = 0; i < FRAME_PIX; i++) tick(0, 1, 8'(i + 1), 0, 10'd0, 0);
        idle(1);
        read_chk("rd_sync_pix", 10'd0, 8'd1);
        tick(0, 1, 8'h77, 0, 10'd0, 0);
        read_chk("rd_idle_pix", 10'd767, 8'd0);

        // reset in the middle of a frame
        do_reset();
        send_frame(FRAME_PIX, 0);
        idle(1);
        send_frame(400, 9);
        do_reset();
        send_frame(FRAME_PIX, 1);
        idle(1);
        chk("id_post_reset", 32'(frame_id), 32'd1);
        chk("drop_post_reset", 32'(drop_cnt), 32'd0);
        chk("avail_post_reset", 32'(frame_avail), 32'd1);

        // random traffic
        do_reset();
        for (int i = 0; i < 30000; i++)
            tick($urandom_range(0, 1499) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
                 1'($urandom), 10'($urandom_range(0, 1023)), $urandom_range(0, 299) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
